// File: rtl/voice_gen.sv
// voice_gen: phase-accumulator voice mixing triangle/saw/pulse/noise with hard sync and ring mod
module voice_gen #(
  parameter int ACC_WIDTH  = 24,
  parameter int FREQ_WIDTH = 16,
  parameter int PW_WIDTH   = 12,
  parameter int OUT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [FREQ_WIDTH-1:0] frequency,
  input  logic [PW_WIDTH-1:0]   pulsewidth,
  input  logic [3:0]            waveform,
  input  logic                  test,
  input  logic                  sync_en,
  input  logic                  sync_in,
  input  logic                  ring_en,
  input  logic                  ring_in,
  output logic [OUT_WIDTH-1:0]  sample,
  output logic                  sync_out,
  output logic                  msb_out
);
  localparam int NB = ACC_WIDTH - 5;
  localparam logic [22:0] SEED = 23'h7FFFFF;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic [22:0] lfsr_q, lfsr_d;
  logic [OUT_WIDTH-1:0] sample_q, sample_d, saw, tri_w, pulse, noise;
  logic sync_q, sync_d, carry, hard, tri_m;
  always_comb begin
    {carry, sum} = {1'b0, acc_q} + (ACC_WIDTH+1)'(frequency);
    hard = sync_en & sync_in;
    acc_d = (test | hard) ? '0 : sum;
    sync_d = carry & ~test & ~hard;
    lfsr_d = test ? SEED
           : (~acc_q[NB] & acc_d[NB]) ? {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]} : lfsr_q;
    saw = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
    tri_m = acc_q[ACC_WIDTH-1] ^ (ring_en & ring_in);
    tri_w = acc_q[ACC_WIDTH-2 -: OUT_WIDTH] ^ {OUT_WIDTH{tri_m}};
    pulse = (acc_q[ACC_WIDTH-1 -: PW_WIDTH] >= pulsewidth) ? '1 : '0;
    noise = lfsr_q[22 -: OUT_WIDTH];
    sample_d = (waveform == 4'b0000) ? '0
             : (waveform[0] ? tri_w : '1) & (waveform[1] ? saw : '1)
             & (waveform[2] ? pulse : '1) & (waveform[3] ? noise : '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      lfsr_q   <= SEED;
      sample_q <= '0;
      sync_q   <= 1'b0;
    end else if (en) begin
      acc_q    <= acc_d;
      lfsr_q   <= lfsr_d;
      sample_q <= sample_d;
      sync_q   <= sync_d;
    end
  end
  assign sample   = sample_q;
  assign sync_out = sync_q;
  assign msb_out  = acc_q[ACC_WIDTH-1];
endmodule

// File: doc/voice_gen.md
# voice_gen

Parametrised multi-waveform oscillator voice, the successor to the single-bit pulse voice. It runs a phase accumulator advanced once per sample strobe. The block produces an OUT_WIDTH-bit sample that is any AND-combination of triangle, sawtooth, pulse and LFSR noise. It adds hard sync and ring modulation between chained voices, and one instance per channel feeds the mixer.

## Interface
Parameters:
- ACC_WIDTH, 24, phase accumulator width; must be ≥ OUT_WIDTH+5 and ≥ PW_WIDTH
- FREQ_WIDTH, 16, frequency word width; must be ≤ ACC_WIDTH
- PW_WIDTH, 12, pulse-width compare width
- OUT_WIDTH, 12, sample width; must be ≤ 23

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  sample strobe; all state updates only on cycles with en=1
- frequency  in  FREQ_WIDTH  phase increment, zero-extended into the accumulator
- pulsewidth  in  PW_WIDTH  pulse threshold; 0 = always high, 1<<(PW_WIDTH-1) = 50%
- waveform  in  4  bit0 triangle, bit1 saw, bit2 pulse, bit3 noise
- test  in  1  holds accumulator at 0 and LFSR at seed
- sync_en  in  1  enables hard sync from sync_in
- sync_in  in  1  master voice's sync_out
- ring_en  in  1  enables ring modulation of triangle
- ring_in  in  1  master voice's msb_out
- sample  out  OUT_WIDTH  registered waveform sample
- sync_out  out  1  registered accumulator-overflow flag
- msb_out  out  1  acc[ACC_WIDTH-1], combinational from register

## Operation
- Let A be the accumulator value at the start of an en cycle. All waveforms are computed from A.
- Accumulator next value, in priority order:
  - test=1: 0
  - sync_en & sync_in: 0
  - otherwise: (A + frequency) mod 2^ACC_WIDTH
- sync_out is loaded with the carry-out of A + frequency. It is 0 when test=1 or when a sync reset occurs.
- Saw: A[ACC_WIDTH-1 -: OUT_WIDTH].
- Triangle: m = A[ACC_WIDTH-1] ^ (ring_en & ring_in). The output is A[ACC_WIDTH-2 -: OUT_WIDTH] XOR {OUT_WIDTH{m}}.
- Pulse: all ones when A[ACC_WIDTH-1 -: PW_WIDTH] ≥ pulsewidth, all zeros otherwise (unsigned compare).
- Noise:
  - 23-bit LFSR, seed 23'h7FFFFF.
  - Step: lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
  - Output: lfsr[22 -: OUT_WIDTH].
  - The LFSR steps on an en cycle when bit ACC_WIDTH-5 is 0 in A and 1 in the next accumulator value.
  - test=1 forces the seed.
- Combine: bitwise AND of all selected waveforms. waveform=4'b0000 gives 0.
- sample <= combined on every en cycle.
- en=0: accumulator, LFSR, sample and sync_out all hold.
- Parameter and input changes take effect at the next en cycle. There is no internal latching of frequency or pulsewidth.

## Timing
- Reset (rst=1 at posedge, regardless of en): accumulator 0, LFSR seed, sample 0, sync_out 0, msb_out 0. Reset takes priority over en and test.
- Latency:
  - sample is valid one clk after the en cycle and reflects A (the pre-update phase).
  - Sample for tick k reflects phase k·frequency.
- sync_out:
  - Asserted from the clk after the overflowing en cycle.
  - Held until the next en cycle, then reloaded.
  - A slave on the same en strobe therefore resets its phase on the tick after the master wraps.
- msb_out follows the accumulator register, so it changes one clk after the en cycle.
- Wrap-around is modular with no saturation. frequency=0 freezes phase but still honours sync and test.
- Simultaneous test and sync: test wins, and sync_out is 0.

## Test plan
- Saw: ACC 24, OUT 12, frequency=0x1000, waveform=0010, en every cycle. Required:
  - sample sequence 0x000, 0x001, 0x002, …, 0xFFF, then 0x000.
  - sync_out high for exactly one clk, following the 4096th en.
  - en held low for 10 cycles mid-run freezes sample and phase.
- Pulse: frequency=0x1000, pulsewidth=0x800, waveform=0100. Required:
  - sample 0x000 for ticks 0–2047, 0xFFF for ticks 2048–4095.
  - pulsewidth=0 gives 0xFFF constantly.
  - pulsewidth=0xFFF gives 0xFFF only on tick 4095.
- Triangle/ring: frequency=0x1000, waveform=0001. Required:
  - sample 0x000, 0x002, …, 0xFFE over ticks 0–2047, then 0xFFF, 0xFFD, …, 0x001.
  - ring_en=1 with ring_in=1 inverts every sample (tick 0 → 0xFFF).
- Hard sync: master frequency=0x1000, slave frequency=0x0C00 with sync_en=1 and sync_in=master.sync_out, shared en. Required: on master tick 4097 the slave sample returns to 0x000 (slave A=0), with no other slave resets in between.
- Noise/test: waveform=1000, frequency=0xFFFF.
  - After reset, sample=0xFFF until the first bit-19 rise; after that step the LFSR is 0x7FFFFE.
  - Asserting test for one en cycle returns accumulator to 0 and LFSR to 0x7FFFFF, and holds sync_out at 0.
- Reset mid-run: assert rst during a saw run with en=1. Required: the next clk shows sample=0, sync_out=0 and msb_out=0, and the phase restarts at 0 on the first en after release.
